// File: rtl/seq_shift_unit_pkg.sv
// Shared types and constants for the sequential shift unit.
package seq_shift_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int AMT_W_DEF = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic SH_LOGICAL = 1'b0;
  localparam logic SH_ARITH   = 1'b1;

  localparam logic SH_LEFT    = 1'b0;
  localparam logic SH_RIGHT   = 1'b1;

endpackage

// File: rtl/seq_shift_unit_if.sv
// Request/response bundle for seq_shift_unit.
// SEQ_SHIFT_FLUSH_EN adds the flush request line.
interface seq_shift_unit_if #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 5
);
  logic                    start;
  logic [WIDTH-1:0]        data_in;
  logic signed [AMT_W-1:0] amt;
  logic                    arith;
  logic                    ready;
  logic                    done;
  logic [WIDTH-1:0]        result;
  logic                    shout;
`ifdef SEQ_SHIFT_FLUSH_EN
  logic                    flush;

  modport master (output start, data_in, amt, arith, flush,
                  input  ready, done, result, shout);
  modport slave  (input  start, data_in, amt, arith, flush,
                  output ready, done, result, shout);
`else
  modport master (output start, data_in, amt, arith,
                  input  ready, done, result, shout);
  modport slave  (input  start, data_in, amt, arith,
                  output ready, done, result, shout);
`endif
endinterface

// File: rtl/seq_shift_unit_shift_step.sv
// One-bit shift step: moves the working word one position and reports
// the bit that falls off the end.
module shift_step
  import seq_shift_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] w,
  input  logic             dir,
  input  logic             arith,
  output logic [WIDTH-1:0] w_next,
  output logic             bit_out
);

  // Left steps shift in zero; right steps fill with sign only when arithmetic.
  always_comb begin
    w_next  = w;
    bit_out = 1'b0;
    if (dir == SH_LEFT) begin
      bit_out = w[WIDTH-1];
      w_next  = {w[WIDTH-2:0], 1'b0};
    end else begin
      bit_out = w[0];
      w_next  = {(arith == SH_ARITH) & w[WIDTH-1], w[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/seq_shift_unit.sv
// Multi-cycle shifter: one bit position per clock under start/ready/done.
// Optional SEQ_SHIFT_FLUSH_EN adds a flush input that aborts an operation.
module seq_shift_unit
  import seq_shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int AMT_W = AMT_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  seq_shift_unit_if.slave     bus
);

  // Magnitude of a signed amount; the most negative value maps onto 2**(AMT_W-1).
  function automatic logic [AMT_W-1:0] amt_mag(input logic signed [AMT_W-1:0] a);
    logic signed [AMT_W-1:0] neg;
    neg = -a;
    return a[AMT_W-1] ? $unsigned(neg) : $unsigned(a);
  endfunction

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   w_q;
  logic [AMT_W-1:0]   cnt_q;
  logic               dir_q;
  logic               mode_q;
  logic [WIDTH-1:0]   result_q;
  logic               shout_q;
  logic               done_q;

  logic [WIDTH-1:0]   w_next;
  logic               bit_out;
  logic [AMT_W-1:0]   mag;
  logic               flush;
  logic               accept;

`ifdef SEQ_SHIFT_FLUSH_EN
  assign flush = bus.flush;
`else
  assign flush = 1'b0;
`endif

  assign mag    = amt_mag(bus.amt);
  assign accept = (state_q == IDLE) && bus.start && !flush;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .w       (w_q),
    .dir     (dir_q),
    .arith   (mode_q),
    .w_next  (w_next),
    .bit_out (bit_out)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode: zero amounts skip straight to DONE, last step enters DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = (mag == '0) ? DONE : SHIFT;
      end
      SHIFT: begin
        if (flush)                    state_d = IDLE;
        else if (cnt_q == AMT_W'(1))  state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Working register, counter and result capture; result/shout only move when entering DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_q      <= '0;
      cnt_q    <= '0;
      dir_q    <= SH_LEFT;
      mode_q   <= SH_LOGICAL;
      result_q <= '0;
      shout_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            w_q    <= bus.data_in;
            cnt_q  <= mag;
            dir_q  <= bus.amt[AMT_W-1];
            mode_q <= bus.arith;
            if (mag == '0) begin
              result_q <= bus.data_in;
              shout_q  <= 1'b0;
              done_q   <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (!flush) begin
            w_q   <= w_next;
            cnt_q <= cnt_q - AMT_W'(1);
            if (cnt_q == AMT_W'(1)) begin
              result_q <= w_next;
              shout_q  <= bit_out;
              done_q   <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ready  = (state_q == IDLE);
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.shout  = shout_q;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Self-checking bench for seq_shift_unit against a plain-arithmetic shift model.
module tb_seq_shift_unit;

  localparam int WIDTH = 16;
  localparam int AMT_W = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seq_shift_unit_if #(.WIDTH(WIDTH), .AMT_W(AMT_W)) bus ();

  seq_shift_unit #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference: shift inside a 32-bit window; the neighbouring bit is the last one out.
  function automatic void model(input logic [15:0] d, input int a, input bit ar,
                                output logic [15:0] r, output logic so);
    logic [31:0]        x;
    logic signed [31:0] xs;
    int n;
    if (a >= 0) begin
      n  = a;
      x  = {16'h0000, d} << n;
      r  = x[15:0];
      so = (n == 0) ? 1'b0 : x[16];
    end else begin
      n = -a;
      if (ar) begin
        xs = $signed({d, 16'h0000}) >>> n;
        r  = xs[31:16];
        so = xs[15];
      end else begin
        x  = {d, 16'h0000} >> n;
        r  = x[31:16];
        so = x[15];
      end
    end
  endfunction

  // Present a request, consume the accepting edge, then scramble the inputs.
  task automatic start_op(input logic [15:0] d, input int a, input bit ar);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.data_in = d;
    bus.amt     = 5'(a);
    bus.arith   = ar;
    @(posedge clk);
    #1;
    bus.start   = 1'b0;
    bus.data_in = 16'($urandom);
    bus.amt     = 5'($urandom);
    bus.arith   = 1'($urandom);
  endtask

  // Wait (bounded) for done; lat counts cycles from the accept edge; returns one cycle after done.
  task automatic wait_done(output int lat, output logic [15:0] r, output logic so, output bit tmo);
    tmo = 1'b1;
    lat = 0;
    r   = 'x;
    so  = 1'bx;
    for (int i = 1; i <= 40; i++) begin
      if (bus.done === 1'b1) begin
        lat = i;
        r   = bus.result;
        so  = bus.shout;
        tmo = 1'b0;
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", bus.ready); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", bus.done); end
    checks++; if (bus.result !== 16'h0000) begin failures++; $display("FAIL reset_result got=%h want=0000", bus.result); end
    checks++; if (bus.shout !== 1'b0) begin failures++; $display("FAIL reset_shout got=%b want=0", bus.shout); end
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    logic [15:0] vd [9] = '{16'h8001, 16'h8000, 16'h8000, 16'h0003, 16'h0003,
                            16'h8000, 16'h8000, 16'h0001, 16'h7FFF};
    int          va [9] = '{4, -4, -4, -1, 0, -16, -16, 15, -16};
    bit          vr [9] = '{0, 1, 0, 0, 0, 1, 0, 1, 1};
    logic [15:0] er [9] = '{16'h0010, 16'hF800, 16'h0800, 16'h0001, 16'h0003,
                            16'hFFFF, 16'h0000, 16'h8000, 16'h0000};
    logic        es [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    int          el [9] = '{5, 5, 5, 2, 1, 17, 17, 16, 17};
    int lat; logic [15:0] r; logic so; bit tmo;
    for (int k = 0; k < 9; k++) begin
      start_op(vd[k], va[k], vr[k]);
      wait_done(lat, r, so, tmo);
      checks++; if (tmo !== 1'b0) begin failures++; $display("FAIL dir%0d_timeout got=no_done want=done", k); end
      checks++; if (r !== er[k]) begin failures++; $display("FAIL dir%0d_result got=%h want=%h", k, r, er[k]); end
      checks++; if (so !== es[k]) begin failures++; $display("FAIL dir%0d_shout got=%b want=%b", k, so, es[k]); end
      checks++; if (lat != el[k]) begin failures++; $display("FAIL dir%0d_latency got=%0d want=%0d", k, lat, el[k]); end
    end
  endtask

  task automatic test_random();
    int lat; logic [15:0] r, d, mr; logic so, ms; bit tmo, ar; int a;
    for (int k = 0; k < 60; k++) begin
      d  = 16'($urandom);
      a  = int'($urandom_range(0, 31)) - 16;
      ar = 1'($urandom);
      model(d, a, ar, mr, ms);
      start_op(d, a, ar);
      wait_done(lat, r, so, tmo);
      checks++;
      if (tmo !== 1'b0 || r !== mr || so !== ms || lat != ((a < 0 ? -a : a) + 1)) begin
        failures++;
        $display("FAIL rand%0d d=%h amt=%0d ar=%0b got=%h/%b/lat%0d want=%h/%b/lat%0d",
                 k, d, a, ar, r, so, lat, mr, ms, (a < 0 ? -a : a) + 1);
      end
    end
  endtask

  task automatic test_drop_start();
    int lat, dones; logic [15:0] r, mr; logic so, ms; bit tmo;
    model(16'h00F0, 6, 1'b0, mr, ms);
    start_op(16'h00F0, 6, 1'b0);
    bus.start   = 1'b1;
    bus.data_in = 16'hFFFF;
    bus.amt     = 5'(-3);
    checks++; if (bus.ready !== 1'b0) begin failures++; $display("FAIL drop_busy_ready got=%b want=0", bus.ready); end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(lat, r, so, tmo);
    checks++; if (tmo !== 1'b0) begin failures++; $display("FAIL drop_timeout got=no_done want=done"); end
    checks++; if (r !== mr) begin failures++; $display("FAIL drop_result got=%h want=%h", r, mr); end
    checks++; if (so !== ms) begin failures++; $display("FAIL drop_shout got=%b want=%b", so, ms); end
    dones = 0;
    repeat (6) begin
      if (bus.done === 1'b1) dones++;
      @(posedge clk);
      #1;
    end
    checks++; if (dones != 0) begin failures++; $display("FAIL drop_queued got=%0d want=0 extra done", dones); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [15:0] r, mr; logic so, ms; bit tmo;
    int seen [$];
    int exp_c [3] = '{3, 7, 11};
    model(16'h1234, 2, 1'b0, mr, ms);
    start_op(16'hA5A5, -3, 1'b1);
    wait_done(lat, r, so, tmo);
    checks++; if (bus.ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_after_done got=%b want=1", bus.ready); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL b2b_done_pulse got=%b want=0", bus.done); end
    bus.start   = 1'b1;
    bus.data_in = 16'h1234;
    bus.amt     = 5'(2);
    bus.arith   = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) begin
        seen.push_back(c);
        checks++; if (bus.result !== mr || bus.shout !== ms) begin failures++; $display("FAIL b2b_result got=%h/%b want=%h/%b", bus.result, bus.shout, mr, ms); end
      end
    end
    bus.start = 1'b0;
    checks++; if (seen.size() != 3) begin failures++; $display("FAIL b2b_count got=%0d want=3", seen.size()); end
    for (int k = 0; k < 3 && k < seen.size(); k++) begin
      checks++; if (seen[k] != exp_c[k]) begin failures++; $display("FAIL b2b_cycle%0d got=%0d want=%0d", k, seen[k], exp_c[k]); end
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int lat, dones; logic [15:0] r, mr; logic so, ms; bit tmo;
    start_op(16'h00FF, 0, 1'b0);
    wait_done(lat, r, so, tmo);
    checks++; if (bus.result !== 16'h00FF) begin failures++; $display("FAIL rmid_pre_result got=%h want=00ff", bus.result); end
    start_op(16'h1234, 10, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (bus.ready !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b want=0", bus.ready); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (bus.ready !== 1'b1) begin failures++; $display("FAIL rmid_ready got=%b want=1", bus.ready); end
    checks++; if (bus.result !== 16'h0000) begin failures++; $display("FAIL rmid_result got=%h want=0000", bus.result); end
    checks++; if (bus.shout !== 1'b0) begin failures++; $display("FAIL rmid_shout got=%b want=0", bus.shout); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    dones = 0;
    repeat (15) begin
      if (bus.done === 1'b1) dones++;
      @(posedge clk);
      #1;
    end
    checks++; if (dones != 0) begin failures++; $display("FAIL rmid_no_done got=%0d want=0", dones); end
    model(16'hC3C3, -5, 1'b1, mr, ms);
    start_op(16'hC3C3, -5, 1'b1);
    wait_done(lat, r, so, tmo);
    checks++; if (tmo !== 1'b0 || r !== mr || so !== ms) begin failures++; $display("FAIL rmid_recover got=%h/%b want=%h/%b", r, so, mr, ms); end
  endtask

`ifdef SEQ_SHIFT_FLUSH_EN
  task automatic test_flush();
    int lat, dones; logic [15:0] r, r0; logic so, s0; bit tmo;
    start_op(16'h0F0F, -2, 1'b0);
    wait_done(lat, r0, s0, tmo);
    start_op(16'h00AA, 8, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    checks++; if (bus.ready !== 1'b1) begin failures++; $display("FAIL flush_ready got=%b want=1", bus.ready); end
    checks++; if (bus.result !== r0 || bus.shout !== s0) begin failures++; $display("FAIL flush_hold got=%h/%b want=%h/%b", bus.result, bus.shout, r0, s0); end
    dones = 0;
    repeat (12) begin
      if (bus.done === 1'b1) dones++;
      @(posedge clk);
      #1;
    end
    checks++; if (dones != 0) begin failures++; $display("FAIL flush_no_done got=%0d want=0", dones); end
    bus.start   = 1'b1;
    bus.flush   = 1'b1;
    bus.data_in = 16'h0001;
    bus.amt     = 5'(3);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    checks++; if (bus.ready !== 1'b1) begin failures++; $display("FAIL flush_idle_prio got=%b want=1", bus.ready); end
    dones = 0;
    repeat (6) begin
      if (bus.done === 1'b1) dones++;
      @(posedge clk);
      #1;
    end
    checks++; if (dones != 0) begin failures++; $display("FAIL flush_idle_done got=%0d want=0", dones); end
    start_op(16'h5A5A, 0, 1'b0);
    bus.flush = 1'b1;
    checks++; if (bus.done !== 1'b1 || bus.result !== 16'h5A5A) begin failures++; $display("FAIL flush_in_done got=%b/%h want=1/5a5a", bus.done, bus.result); end
    @(posedge clk); #1;
    bus.flush = 1'b0;
  endtask
`endif

  initial begin
    bus.start   = 1'b0;
    bus.data_in = '0;
    bus.amt     = '0;
    bus.arith   = 1'b0;
`ifdef SEQ_SHIFT_FLUSH_EN
    bus.flush   = 1'b0;
`endif
    test_reset();
    test_directed();
    test_random();
    test_drop_start();
    test_back_to_back();
    test_reset_mid();
`ifdef SEQ_SHIFT_FLUSH_EN
    test_flush();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
